sdp_rd_req_arb: RTL and testbench
=================================

SDP_RD_REQ_ARB -- requirements
Module: sdp_rd_req_arb

Interface
REQ-001 SHALL have parameter PD_W, default 47, read-request payload width (address 32 + size 15).
REQ-002 SHALL have parameter MAX_OUTST, default 8, maximum outstanding (unpopped) requests per requester, range 1..15.
REQ-003 One clock and one reset, both fixed: nvdla_core_clk is the single clock; nvdla_core_rst is a synchronous, active-high reset.
REQ-004 SHALL have port nvdla_core_clk, input, 1, the sole clock.
REQ-005 SHALL have port nvdla_core_rst, input, 1, the synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 3, per-requester request valid; bit 0 = mrdma, bit 1 = brdma, bit 2 = nrdma.
REQ-007 SHALL have port req_ready, output, 3, per-requester accept.
REQ-008 SHALL have port req_pd, input, 3*PD_W, per-requester payloads; requester i occupies bits [i*PD_W +: PD_W].
REQ-009 SHALL have port lat_fifo_pop, input, 3, per-requester credit return (one response consumed).
REQ-010 SHALL have port out_valid, output, 1, merged request valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accept.
REQ-012 SHALL have port out_pd, output, PD_W, merged request payload.
REQ-013 SHALL have port out_src, output, 2, source id of the presented request (0..2).
REQ-014 SHALL have port outst_cnt, output, 3x4 bits, per-requester outstanding count.
REQ-015 SHALL have port idle, output, 1, asserted when there is no pending output and all counts are 0.
REQ-016 SHALL have port err_underflow, output, 1, one-cycle pulse on a pop received while the matching count is 0.

Function
REQ-017 Eligibility: requester i SHALL be eligible when req_valid[i]=1 and outst_cnt[i] < MAX_OUTST.
REQ-018 Arbitration: among eligible requesters, the grant SHALL be round-robin, starting the search at rr_ptr.
REQ-019 Pointer update: on each accept, rr_ptr SHALL become (winner+1) mod 3; otherwise rr_ptr holds.
REQ-020 Output stage: the output SHALL be a single register stage; it can load when out_valid=0 or out_ready=1.
REQ-021 Ready: req_ready[i] SHALL be 1 only when i is the winner and the output stage can load.
REQ-022 Ready rules: at most one bit of req_ready is high per cycle, and req_ready is independent of out_pd.
REQ-023 Latency: a request accepted in cycle N SHALL present out_valid, out_pd and out_src in cycle N+1.
REQ-024 Stall: while out_valid=1 and out_ready=0, out_pd and out_src SHALL be held stable.
REQ-025 Back-to-back: with out_ready held at 1, the block SHALL accept one request per cycle.
REQ-026 Count increment: outst_cnt[i] SHALL increment on an accept from requester i.
REQ-027 Count decrement: outst_cnt[i] SHALL decrement on lat_fifo_pop[i].
REQ-028 Simultaneous accept and pop on the same requester: the count SHALL stay unchanged.
REQ-029 Underflow: a pop with count 0 (and no accept) SHALL leave the count at 0 and pulse err_underflow in the next cycle.
REQ-030 Full: at count = MAX_OUTST the requester SHALL be masked and its req_ready held at 0.
REQ-031 Full plus pop: a pop in the same cycle as full SHALL not unmask the requester until the following cycle, because eligibility uses the registered count.
REQ-032 idle SHALL be combinational from registered state only.

Reset
REQ-033 While nvdla_core_rst=1 at a clock edge, the block SHALL clear out_valid, out_pd, out_src, rr_ptr, every outst_cnt and err_underflow.
REQ-034 During reset, req_ready SHALL be 000 and idle SHALL be 1.
REQ-035 A reset asserted mid-operation SHALL drop any pending output request and all credit counts with no drain.
REQ-036 No input SHALL be sampled in a reset cycle.

Structure
REQ-037 A shared package SHALL hold the PD_W default, the requester id constants (MRDMA=0, BRDMA=1, NRDMA=2) and the count width.
REQ-038 The credit counter SHALL be one sub-module, sdp_rd_credit_cnt, instantiated three times.
REQ-039 The arbiter and the output register SHALL be inline in the top module.

Verification
REQ-040 Round-robin: all three valid continuously, out_ready=1 from reset -> out_src sequence 0,1,2,0,1,2, one per cycle, first out_valid 1 cycle after the first accept.
REQ-041 Stall hold: out_ready=0 for 5 cycles with a request pending -> out_pd and out_src constant, req_ready=000, no count change.
REQ-042 Credit full: only brdma valid, MAX_OUTST=8, no pops -> exactly 8 accepts, outst_cnt[1]=8, req_ready[1]=0; one pop -> accept resumes after 1 cycle.
REQ-043 Simultaneous accept and pop on nrdma at count 3 -> count stays 3; pop at count 0 -> count 0 and err_underflow high for 1 cycle.
REQ-044 Masking: mrdma full and nrdma valid -> nrdma granted every cycle, mrdma never granted.
REQ-045 Reset mid-stall with counts {2,5,1} -> next cycle out_valid=0, all counts 0, idle=1, rr_ptr=0.

Source files
------------

// File: rtl/sdp_rd_req_arb_pkg.sv
// Shared constants for the SDP read-request arbiter.
// Requester ids, payload width default and credit count width.
package sdp_rd_req_arb_pkg;

    localparam int PD_W_DEF = 47;
    localparam int NREQ     = 3;
    localparam int CNT_W    = 4;

    localparam logic [1:0] MRDMA = 2'd0;
    localparam logic [1:0] BRDMA = 2'd1;
    localparam logic [1:0] NRDMA = 2'd2;

    typedef logic [CNT_W-1:0] cnt_t;

    // Next requester id in round-robin order, wrapping after NRDMA.
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == NRDMA) ? MRDMA : id + 2'd1;
    endfunction

endpackage

// File: rtl/sdp_rd_credit_cnt.sv
// Per-requester outstanding-request counter.
// Increments on accept, decrements on response pop, flags pops at zero.
module sdp_rd_credit_cnt
    import sdp_rd_req_arb_pkg::*;
#(
    parameter int MAX_OUTST = 8
) (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rst,
    input  logic inc,
    input  logic dec,
    output cnt_t cnt,
    output logic full,
    output logic underflow
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Next count; accept and pop together cancel, pop at zero saturates.
    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (inc && !dec) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                underflow = 1'b1;
            end else begin
                cnt_d = cnt_q - cnt_t'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q >= cnt_t'(MAX_OUTST));

endmodule

// File: rtl/sdp_rd_req_arb.sv
// Three-way round-robin read-request arbiter with per-source credit
// limits and a single registered output stage.
module sdp_rd_req_arb
    import sdp_rd_req_arb_pkg::*;
#(
    parameter int PD_W      = PD_W_DEF,
    parameter int MAX_OUTST = 8
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*PD_W-1:0]    req_pd,
    input  logic [NREQ-1:0]         lat_fifo_pop,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PD_W-1:0]         out_pd,
    output logic [1:0]              out_src,
    output logic [NREQ*CNT_W-1:0]   outst_cnt,
    output logic                    idle,
    output logic                    err_underflow
);

    logic [1:0]      rr_ptr_q,    rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [PD_W-1:0] out_pd_q,    out_pd_d;
    logic [1:0]      out_src_q,   out_src_d;
    logic            err_q,       err_d;

    logic [3:0]      elig;
    logic [NREQ-1:0] full;
    logic [NREQ-1:0] uflow;
    logic [1:0]      c0, c1, c2;
    logic [1:0]      win_id;
    logic            win_vld;
    logic            can_load;
    logic            accept;

    // Credit counters, one per requester; pops are ignored in reset.
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        sdp_rd_credit_cnt #(
            .MAX_OUTST (MAX_OUTST)
        ) u_cnt (
            .nvdla_core_clk (nvdla_core_clk),
            .nvdla_core_rst (nvdla_core_rst),
            .inc            (req_ready[i]),
            .dec            (lat_fifo_pop[i] & ~nvdla_core_rst),
            .cnt            (outst_cnt[i*CNT_W +: CNT_W]),
            .full           (full[i]),
            .underflow      (uflow[i])
        );
    end

    // Round-robin pick among eligible requesters, starting at rr_ptr.
    always_comb begin
        elig    = {1'b0, req_valid & ~full};
        c0      = rr_ptr_q;
        c1      = rr_next(c0);
        c2      = rr_next(c1);
        win_vld = 1'b1;
        win_id  = c0;
        priority case (1'b1)
            elig[c0]: win_id = c0;
            elig[c1]: win_id = c1;
            elig[c2]: win_id = c2;
            default:  win_vld = 1'b0;
        endcase
    end

    assign can_load  = ~out_valid_q | out_ready;
    assign accept    = win_vld & can_load & ~nvdla_core_rst;
    assign req_ready = accept ? (3'b001 << win_id) : 3'b000;

    // Output stage load/hold, pointer advance and underflow pulse.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_pd_d    = out_pd_q;
        out_src_d   = out_src_q;
        err_d       = |uflow;
        if (accept) begin
            out_valid_d = 1'b1;
            out_pd_d    = req_pd[int'(win_id)*PD_W +: PD_W];
            out_src_d   = win_id;
            rr_ptr_d    = rr_next(win_id);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any pending output with no drain.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rr_ptr_q    <= MRDMA;
            out_valid_q <= 1'b0;
            out_pd_q    <= '0;
            out_src_q   <= MRDMA;
            err_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_pd_q    <= out_pd_d;
            out_src_q   <= out_src_d;
            err_q       <= err_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pd        = out_pd_q;
    assign out_src       = out_src_q;
    assign err_underflow = err_q;
    assign idle          = ~out_valid_q & (outst_cnt == '0);

endmodule

// File: tb/tb_sdp_rd_req_arb.sv
// Self-checking bench for sdp_rd_req_arb: directed scenarios with
// literal expectations plus a randomized run against a queue-free model.
module tb_sdp_rd_req_arb;

    localparam int PD_W = 47;
    localparam int MAXO = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [2:0]         req_valid;
    logic [2:0]         req_ready;
    logic [3*PD_W-1:0]  req_pd;
    logic [2:0]         lat_fifo_pop;
    logic               out_valid;
    logic               out_ready;
    logic [PD_W-1:0]    out_pd;
    logic [1:0]         out_src;
    logic [11:0]        outst_cnt;
    logic               idle;
    logic               err_underflow;

    int tests  = 0;
    int failed = 0;

    // behavioural model state
    int              m_cnt [3];
    int              m_ptr;
    bit              m_ov;
    logic [PD_W-1:0] m_pd;
    int              m_src;
    bit              m_err;
    logic [2:0]      exp_rdy;
    logic [2:0]      last_rdy;

    sdp_rd_req_arb #(.PD_W(PD_W), .MAX_OUTST(MAXO)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pd         (req_pd),
        .lat_fifo_pop   (lat_fifo_pop),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pd         (out_pd),
        .out_src        (out_src),
        .outst_cnt      (outst_cnt),
        .idle           (idle),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] dcnt(input int i);
        return outst_cnt[i*4 +: 4];
    endfunction

    // Compare every registered output with the model.
    task automatic check_regs();
        bit m_idle;
        m_idle = !m_ov && m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0;
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        chk("out_pd", 64'(out_pd), 64'(m_pd));
        chk("out_src", 64'(out_src), 64'(m_src));
        for (int i = 0; i < 3; i++)
            chk($sformatf("cnt%0d", i), 64'(dcnt(i)), 64'(m_cnt[i]));
        chk("idle", 64'(idle), 64'(m_idle));
        chk("err_underflow", 64'(err_underflow), 64'(m_err));
    endtask

    // One clock: check state, drive inputs, check ready, advance model.
    task automatic cyc(input bit r, input logic [2:0] v,
                       input logic [2:0] p, input bit rdy);
        logic [159:0] rnd;
        int win;
        bit acc;
        @(negedge clk);
        check_regs();
        rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
        rst          = r;
        req_valid    = v;
        lat_fifo_pop = p;
        out_ready    = rdy;
        req_pd       = rnd[3*PD_W-1:0];
        #1;
        win = -1;
        for (int k = 0; k < 3; k++) begin
            int j;
            j = (m_ptr + k) % 3;
            if (win < 0 && v[j] && m_cnt[j] < MAXO) win = j;
        end
        acc = !r && win >= 0 && (!m_ov || rdy);
        exp_rdy = acc ? 3'(1 << win) : 3'b000;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        last_rdy = req_ready;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            m_ptr = 0; m_ov = 0; m_pd = '0; m_src = 0; m_err = 0;
        end else begin
            m_err = 0;
            for (int i = 0; i < 3; i++) begin
                bit inc;
                inc = acc && win == i;
                if (inc && !p[i]) m_cnt[i]++;
                else if (p[i] && !inc) begin
                    if (m_cnt[i] == 0) m_err = 1;
                    else m_cnt[i]--;
                end
            end
            if (acc) begin
                m_ov  = 1;
                m_pd  = req_pd[win*PD_W +: PD_W];
                m_src = win;
                m_ptr = (win + 1) % 3;
            end else if (rdy) begin
                m_ov = 0;
            end
        end
        #1;
    endtask

    initial begin
        int acc_cnt;
        logic [2:0] v, p;
        rst = 1; req_valid = 0; lat_fifo_pop = 0; out_ready = 0;
        req_pd = '0;
        m_ptr = 0; m_ov = 0; m_pd = '0; m_src = 0; m_err = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;

        // reset state, with inputs active during reset
        cyc(1, 3'b111, 3'b111, 1);
        chk("rst_ready", 64'(last_rdy), 64'd0);
        cyc(1, 3'b111, 3'b000, 1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_cnt", 64'(outst_cnt), 64'd0);

        // round-robin 0,1,2,0,1,2 back-to-back
        for (int n = 0; n < 6; n++) begin
            cyc(0, 3'b111, 3'b000, 1);
            chk("rr_valid", 64'(out_valid), 64'd1);
            chk("rr_src", 64'(out_src), 64'(n % 3));
        end

        // stall: pending request held for 5 cycles
        for (int n = 0; n < 5; n++) begin
            cyc(0, 3'b111, 3'b000, 0);
            chk("stall_ready", 64'(last_rdy), 64'd0);
            chk("stall_src", 64'(out_src), 64'd2);
            chk("stall_cnt", 64'(outst_cnt), 64'h222);
        end

        // credit full on brdma
        cyc(1, 3'b000, 3'b000, 1);
        acc_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            cyc(0, 3'b010, 3'b000, 1);
            if (last_rdy[1]) acc_cnt++;
        end
        chk("full_accepts", 64'(acc_cnt), 64'd8);
        chk("full_cnt", 64'(dcnt(1)), 64'd8);
        cyc(0, 3'b010, 3'b010, 1);
        chk("full_pop_ready", 64'(last_rdy), 64'd0);
        cyc(0, 3'b010, 3'b000, 1);
        chk("full_resume", 64'(last_rdy), 64'b010);

        // simultaneous accept+pop on nrdma, then underflow
        cyc(1, 3'b000, 3'b000, 1);
        for (int n = 0; n < 3; n++) cyc(0, 3'b100, 3'b000, 1);
        chk("nr_cnt3", 64'(dcnt(2)), 64'd3);
        cyc(0, 3'b100, 3'b100, 1);
        chk("nr_same", 64'(dcnt(2)), 64'd3);
        for (int n = 0; n < 3; n++) cyc(0, 3'b000, 3'b100, 1);
        chk("nr_cnt0", 64'(dcnt(2)), 64'd0);
        chk("nr_noerr", 64'(err_underflow), 64'd0);
        cyc(0, 3'b000, 3'b100, 1);
        chk("uf_cnt", 64'(dcnt(2)), 64'd0);
        chk("uf_err", 64'(err_underflow), 64'd1);
        cyc(0, 3'b000, 3'b000, 1);
        chk("uf_pulse", 64'(err_underflow), 64'd0);

        // masking: mrdma full, nrdma always wins
        cyc(1, 3'b000, 3'b000, 1);
        for (int n = 0; n < 8; n++) cyc(0, 3'b001, 3'b000, 1);
        for (int n = 0; n < 5; n++) begin
            cyc(0, 3'b101, 3'b000, 1);
            chk("mask_rdy", 64'(last_rdy), 64'b100);
        end

        // reset mid-stall with counts {2,5,1}
        cyc(1, 3'b000, 3'b000, 1);
        for (int n = 0; n < 2; n++) cyc(0, 3'b001, 3'b000, 1);
        for (int n = 0; n < 5; n++) cyc(0, 3'b010, 3'b000, 1);
        cyc(0, 3'b100, 3'b000, 1);
        cyc(0, 3'b000, 3'b000, 0);
        chk("pre_cnt", 64'(outst_cnt), 64'h152);
        chk("pre_valid", 64'(out_valid), 64'd1);
        cyc(1, 3'b111, 3'b111, 0);
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_cnt", 64'(outst_cnt), 64'd0);
        chk("mid_idle", 64'(idle), 64'd1);
        cyc(0, 3'b111, 3'b000, 1);
        chk("mid_ptr", 64'(out_src), 64'd0);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            v = 3'($urandom);
            p = 3'($urandom) & 3'($urandom);
            cyc(($urandom_range(0, 249) == 0), v, p,
                ($urandom_range(0, 3) != 0));
        end
        @(negedge clk);
        check_regs();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
